// File: rtl/div_seq_unit.sv
// Multi-cycle restoring divider answering the ALU DIV/DIVU handshake.
// Quotient is returned on Lo, remainder on Hi, with a one-cycle validOut pulse.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_C    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO_C = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] cond_neg_f(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + ONE_C;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] quo_r, quo_s;
  logic [WIDTH-1:0] dvs_r, dvs_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [CW-1:0]    count_r, count_s;
  logic             q_neg_r, q_neg_s;
  logic             r_neg_r, r_neg_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r   <= ZERO_C;
      dvs_r   <= ZERO_C;
      rem_r   <= ZERO_C;
      count_r <= CNT_ZERO_C;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      hi_r    <= ZERO_C;
      lo_r    <= ZERO_C;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      quo_r   <= quo_s;
      dvs_r   <= dvs_s;
      rem_r   <= rem_s;
      count_r <= count_s;
      q_neg_r <= q_neg_s;
      r_neg_r <= r_neg_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state, one restoring iteration per CALC cycle, and result fix-up.
  always_comb begin
    state_s = state_r;
    quo_s   = quo_r;
    dvs_s   = dvs_r;
    rem_s   = rem_r;
    count_s = count_r;
    q_neg_s = q_neg_r;
    r_neg_s = r_neg_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    valid_s = 1'b0;
    busy_s  = busy_r;
    // The remainder never exceeds the divisor, so one extra bit holds the trial result sign.
    shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dvs_r};

    case (state_r)
      IDLE: begin
        if (validIn) begin
          state_s = CALC;
          quo_s   = cond_neg_f(SrcA, sign & SrcA[WIDTH-1]);
          dvs_s   = cond_neg_f(SrcB, sign & SrcB[WIDTH-1]);
          q_neg_s = sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          r_neg_s = sign & SrcA[WIDTH-1];
          rem_s   = ZERO_C;
          count_s = CNT_ZERO_C;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      CALC: begin
        if (!validIn) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          if (!diff_s[WIDTH]) begin
            rem_s = diff_s[WIDTH-1:0];
            quo_s = {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_s = shift_s[WIDTH-1:0];
            quo_s = {quo_r[WIDTH-2:0], 1'b0};
          end
          count_s = count_r + CNT_ONE_C;
          if (count_r == LAST_C) begin
            state_s = FIX;
          end else begin
            state_s = CALC;
          end
        end
      end
      FIX: begin
        lo_s    = cond_neg_f(quo_r, q_neg_r);
        hi_s    = cond_neg_f(rem_r, r_neg_r);
        valid_s = 1'b1;
        busy_s  = 1'b0;
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign validOut = valid_r;
  assign Hi       = hi_r;
  assign Lo       = lo_r;
  assign busy     = busy_r;

endmodule
